demosaic_frame_ctrl: RTL and testbench

Frame sequencer that sits in front of the demosaic core. It accepts one Bayer frame from the sensor-side stream and forwards it beat by beat to the core. It then injects the zero-valued flush beats the core's line buffers need to drain, waits for the core's done pulse, and pulses the core's reset between frames. It also reports frame count and protocol errors to the ISP top level.

---
 rtl/isp_ctrl_pkg.sv | 19 +
 rtl/frame_pos_counter.sv | 51 +++++
 rtl/demosaic_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_demosaic_frame_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/isp_ctrl_pkg.sv
// rtl/isp_ctrl_pkg.sv - shared ISP control types, constants and helpers
package isp_ctrl_pkg;

   localparam int PIX_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      FLUSH  = 3'd2,
      DRAIN  = 3'd3,
      CLEAR  = 3'd4
   } ctrl_state_e;

   // Zero beats needed to push the last row through a kernel-high line buffer.
   function automatic int flush_cycles(input int width, input int kernel);
      return width * ((kernel - 1) / 2 + 1);
   endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - x/y raster position counter with clear, enable and last-pixel flag
module frame_pos_counter #(
   parameter int WIDTH  = 1920,
   parameter int HEIGHT = 1080
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] x_o,
   output logic [15:0] y_o,
   output logic        last_o
);

   localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr_i) begin
         x_d = '0;
         y_d = '0;
      end else if (en_i) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
         end else begin
            x_d = x_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// rtl/demosaic_frame_ctrl.sv - frame sequencer feeding, flushing and resetting the demosaic core
// Optional drain watchdog: DEMOSAIC_CTRL_TIMEOUT_EN.
module demosaic_frame_ctrl
   import isp_ctrl_pkg::*;
#(
   parameter int WIDTH          = 1920,
   parameter int HEIGHT         = 1080,
   parameter int KERNEL_SIZE    = 7,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iStart,
   input  logic             iContinuous,
   input  logic [PIX_W-1:0] iData,
   input  logic             iValid,
   output logic             oReady,
   output logic [PIX_W-1:0] dmData,
   output logic             dmValid,
   output logic             dmReset,
   input  logic             dmDone,
   output logic             oBusy,
   output logic             oFrameDone,
   output logic [15:0]      oFrameCnt,
   output logic             oErr
);

   localparam logic [31:0] FLUSH_LAST = 32'(flush_cycles(WIDTH, KERNEL_SIZE) - 1);
   localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

   ctrl_state_e      state_q;
   logic             ready_q;
   logic [PIX_W-1:0] data_q;
   logic             valid_q;
   logic             dmrst_q;
   logic             busy_q;
   logic             done_q;
   logic [15:0]      cnt_q;
   logic             err_q;
   logic [31:0]      flush_q;
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
   logic [31:0]      tmo_q;
`endif

   logic        accept;
   logic        pos_clr;
   logic        pos_last;
   logic [15:0] pos_x_unused;
   logic [15:0] pos_y_unused;

   assign accept  = iValid && ready_q;
   assign pos_clr = ((state_q == IDLE) && iStart) || ((state_q == CLEAR) && iContinuous);

   frame_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_pos (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (pos_clr),
      .en_i   (accept),
      .x_o    (pos_x_unused),
      .y_o    (pos_y_unused),
      .last_o (pos_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         dmrst_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         flush_q <= '0;
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         if (dmDone && (state_q != DRAIN))
            err_q <= 1'b1;
         // Overrun: sensor pushed a beat while we were not accepting, outside IDLE.
         if (iValid && !ready_q &&
             ((state_q == FLUSH) || (state_q == DRAIN) || (state_q == CLEAR)))
            err_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (iStart) begin
                  state_q <= STREAM;
                  ready_q <= 1'b1;
                  dmrst_q <= 1'b0;
                  busy_q  <= 1'b1;
                  flush_q <= '0;
               end
            end
            STREAM: begin
               if (accept) begin
                  data_q  <= iData;
                  valid_q <= 1'b1;
                  if (pos_last) begin
                     state_q <= FLUSH;
                     ready_q <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               data_q  <= '0;
               valid_q <= 1'b1;
               flush_q <= flush_q + 32'd1;
               if (flush_q == FLUSH_LAST) begin
                  state_q <= DRAIN;
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end
            end
            DRAIN: begin
               if (dmDone) begin
                  state_q <= CLEAR;
                  dmrst_q <= 1'b1;
                  done_q  <= 1'b1;
                  cnt_q   <= cnt_q + 16'd1;
               end
`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  state_q <= CLEAR;
                  dmrst_q <= 1'b1;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
`endif
            end
            CLEAR: begin
               if (iContinuous) begin
                  state_q <= STREAM;
                  ready_q <= 1'b1;
                  dmrst_q <= 1'b0;
                  flush_q <= '0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
               dmrst_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifndef DEMOSAIC_CTRL_TIMEOUT_EN
   logic [31:0] tmo_last_unused;
   assign tmo_last_unused = TMO_LAST;
`endif

   assign oReady     = ready_q;
   assign dmData     = data_q;
   assign dmValid    = valid_q;
   assign dmReset    = dmrst_q;
   assign oBusy      = busy_q;
   assign oFrameDone = done_q;
   assign oFrameCnt  = cnt_q;
   assign oErr       = err_q;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// tb/tb_demosaic_frame_ctrl.sv - directed self-checking bench for demosaic_frame_ctrl (4x4 frame, 16 flush beats)
module tb_demosaic_frame_ctrl;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int NPIX  = W * H;
   localparam int NFLSH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iStart = 1'b0;
   logic        iContinuous = 1'b0;
   logic [7:0]  iData = 8'd0;
   logic        iValid = 1'b0;
   logic        oReady;
   logic [7:0]  dmData;
   logic        dmValid;
   logic        dmReset;
   logic        dmDone = 1'b0;
   logic        oBusy;
   logic        oFrameDone;
   logic [15:0] oFrameCnt;
   logic        oErr;

   int checks = 0;
   int failures = 0;
   logic [7:0] beats[$];

   demosaic_frame_ctrl #(
      .WIDTH          (W),
      .HEIGHT         (H),
      .KERNEL_SIZE    (7),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .iStart      (iStart),
      .iContinuous (iContinuous),
      .iData       (iData),
      .iValid      (iValid),
      .oReady      (oReady),
      .dmData      (dmData),
      .dmValid     (dmValid),
      .dmReset     (dmReset),
      .dmDone      (dmDone),
      .oBusy       (oBusy),
      .oFrameDone  (oFrameDone),
      .oFrameCnt   (oFrameCnt),
      .oErr        (oErr)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!reset && dmValid) beats.push_back(dmData);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_frame(input logic [7:0] first, input bit gap, input bit start);
      beats.delete();
      if (start) begin
         iStart = 1'b1;
         tick();
         iStart = 1'b0;
      end
      check_eq("ready_hi", oReady, 1);
      for (int i = 0; i < NPIX; i++) begin
         iValid = 1'b1;
         iData  = first + 8'(i);
         tick();
         if (gap) begin
            iValid = 1'b0;
            tick();
         end
      end
      iValid = 1'b0;
      check_eq("ready_fall", oReady, 0);
   endtask

   task automatic wait_flushed();
      int n = 0;
      while (beats.size() < NPIX + NFLSH && n < 200) begin
         tick();
         n++;
      end
      check_eq("flush_bound", n < 200, 1);
      tick();
      check_eq("drain_valid", dmValid, 0);
   endtask

   task automatic check_beats(input logic [7:0] first);
      logic [31:0] got;
      check_eq("beat_count", beats.size(), NPIX + NFLSH);
      for (int i = 0; i < NPIX + NFLSH; i++) begin
         got = (i < beats.size()) ? 32'(beats[i]) : 32'hDEAD;
         check_eq($sformatf("beat%0d", i), got, (i < NPIX) ? 32'(first + 8'(i)) : 32'd0);
      end
   endtask

   task automatic finish_frame(input logic [7:0] first, input int exp_cnt, input bit cont);
      wait_flushed();
      dmDone = 1'b1;
      tick();
      dmDone = 1'b0;
      check_eq("clr_dmreset", dmReset, 1);
      check_eq("clr_done", oFrameDone, 1);
      check_eq("clr_cnt", oFrameCnt, exp_cnt);
      check_eq("clr_busy", oBusy, 1);
      tick();
      check_eq("done_pulse", oFrameDone, 0);
      check_beats(first);
      if (cont) begin
         check_eq("cont_dmreset", dmReset, 0);
         check_eq("cont_busy", oBusy, 1);
      end else begin
         check_eq("idle_dmreset", dmReset, 1);
         check_eq("idle_busy", oBusy, 0);
      end
   endtask

   initial begin
      tick();
      check_eq("rst_ready", oReady, 0);
      check_eq("rst_valid", dmValid, 0);
      check_eq("rst_data", dmData, 0);
      check_eq("rst_dmreset", dmReset, 1);
      check_eq("rst_busy", oBusy, 0);
      check_eq("rst_cnt", oFrameCnt, 0);
      check_eq("rst_err", oErr, 0);
      reset = 1'b0;
      tick();

      // back-to-back frame, then the same frame with iValid toggling
      run_frame(8'd1, 1'b0, 1'b1);
      finish_frame(8'd1, 1, 1'b0);
      run_frame(8'd17, 1'b1, 1'b1);
      finish_frame(8'd17, 2, 1'b0);
      check_eq("clean_err", oErr, 0);

      // continuous: two frames with a single dmReset cycle between them
      apply_reset();
      iContinuous = 1'b1;
      run_frame(8'd33, 1'b0, 1'b1);
      finish_frame(8'd33, 1, 1'b1);
      iContinuous = 1'b0;
      run_frame(8'd49, 1'b0, 1'b0);
      finish_frame(8'd49, 2, 1'b0);
      check_eq("cont_err", oErr, 0);

      // overrun during FLUSH
      apply_reset();
      run_frame(8'd65, 1'b0, 1'b1);
      iValid = 1'b1;
      iData  = 8'hAA;
      tick();
      iValid = 1'b0;
      check_eq("ovr_err", oErr, 1);
      finish_frame(8'd65, 1, 1'b0);
      check_eq("ovr_sticky", oErr, 1);

      // stray dmDone during STREAM
      apply_reset();
      check_eq("rst2_err", oErr, 0);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      dmDone = 1'b1;
      tick();
      dmDone = 1'b0;
      check_eq("stray_done_err", oErr, 1);

      // async reset mid-frame, then a fresh frame
      apply_reset();
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int i = 0; i < 7; i++) begin
         iValid = 1'b1;
         iData  = 8'd100 + 8'(i);
         tick();
      end
      iValid = 1'b0;
      reset  = 1'b1;
      #1;
      check_eq("mid_dmreset", dmReset, 1);
      check_eq("mid_valid", dmValid, 0);
      check_eq("mid_busy", oBusy, 0);
      check_eq("mid_cnt", oFrameCnt, 0);
      tick();
      reset = 1'b0;
      tick();
      run_frame(8'd200, 1'b0, 1'b1);
      finish_frame(8'd200, 1, 1'b0);

`ifdef DEMOSAIC_CTRL_TIMEOUT_EN
      begin
         int n = 0;
         apply_reset();
         run_frame(8'd1, 1'b0, 1'b1);
         wait_flushed();
         while (!oFrameDone && n < 40) begin
            tick();
            n++;
         end
         check_eq("tmo_bound", n < 40, 1);
         check_eq("tmo_done", oFrameDone, 1);
         check_eq("tmo_err", oErr, 1);
         check_eq("tmo_cnt", oFrameCnt, 0);
         check_eq("tmo_dmreset", dmReset, 1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
